// File: rtl/ingress_mux_nport.sv
// ingress_mux_nport: round-robin N-port frame multiplexer into a shared backend data/pointer FIFO pair
//   clk_sys/rstn_sys         clock, async active-low reset
//   port_en                  per-port request mask
//   rx_ptr_fifo_*            per-port pointer FIFOs {err[2:0], len[12:0]}, dout valid the cycle after rd
//   rx_data_fifo_*           per-port byte FIFOs, dout valid the cycle after rd
//   sfifo_*                  backend data FIFO write side and occupancy
//   ptr_sfifo_*              backend pointer FIFO write side {1'b0, src one-hot, len}
//   pkt_cnt/drop_cnt         saturating forwarded/dropped frame counters
module ingress_mux_nport #(
  parameter int NPORTS     = 4,
  parameter int LEN_W      = 11,
  parameter int MAX_LEN    = 1518,
  parameter int DCNT_W     = 12,
  parameter int DATA_DEPTH = 4096
) (
  input  logic                    clk_sys,
  input  logic                    rstn_sys,
  input  logic [NPORTS-1:0]       port_en,
  input  logic [NPORTS-1:0]       rx_ptr_fifo_empty,
  output logic [NPORTS-1:0]       rx_ptr_fifo_rd,
  input  logic [16*NPORTS-1:0]    rx_ptr_fifo_dout,
  output logic [NPORTS-1:0]       rx_data_fifo_rd,
  input  logic [8*NPORTS-1:0]     rx_data_fifo_dout,
  output logic                    sfifo_wr,
  output logic [7:0]              sfifo_din,
  input  logic [DCNT_W-1:0]       sfifo_cnt,
  output logic                    ptr_sfifo_wr,
  output logic [NPORTS+LEN_W:0]   ptr_sfifo_din,
  input  logic                    ptr_sfifo_full,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             drop_cnt
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [12:0] MAXL = 13'(MAX_LEN);
  localparam logic [DCNT_W-1:0] BP_TH = DCNT_W'(DATA_DEPTH - MAX_LEN);
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GRANT = 5'b00010,
    HDR   = 5'b00100,
    DATA  = 5'b01000,
    DONE  = 5'b10000
  } state_t;
  state_t state_q, state_d;
  logic [NPORTS-1:0] sel_q, sel_d, req, gnt;
  logic [PW-1:0] rr_q, rr_d, rr_nxt, idx;
  logic [12:0] len_q, len_d, cnt_q, cnt_d;
  logic err_q, err_d, bp_q;
  logic [15:0] ptr_word;
  logic [7:0] dat_byte;
  logic sfifo_wr_q, ptr_wr_q;
  logic [NPORTS+LEN_W:0] ptr_din_q;
  logic [15:0] pkt_q, drop_q;
  assign req = port_en & ~rx_ptr_fifo_empty;
  // Scan offsets from the far end down so the smallest offset from rr_q wins.
  always_comb begin
    gnt = '0;
    rr_nxt = rr_q;
    idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % NPORTS);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        rr_nxt = PW'((int'(rr_q) + i + 1) % NPORTS);
      end
    end
  end
  always_comb begin
    ptr_word = '0;
    dat_byte = '0;
    for (int k = 0; k < NPORTS; k++) begin
      ptr_word = ptr_word | (sel_q[k] ? rx_ptr_fifo_dout[16*k +: 16] : 16'h0);
      dat_byte = dat_byte | (sel_q[k] ? rx_data_fifo_dout[8*k +: 8] : 8'h0);
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_d = rr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (|req && !bp_q) begin
        state_d = GRANT;
        sel_d = gnt;
        rr_d = rr_nxt;
      end
      GRANT: state_d = HDR;
      HDR: begin
        len_d = ptr_word[12:0];
        err_d = |ptr_word[15:13] || ptr_word[12:0] == 13'd0 || ptr_word[12:0] > MAXL;
        cnt_d = 13'd1;
        state_d = (ptr_word[12:0] == 13'd0) ? DONE : DATA;
      end
      DATA: begin
        cnt_d = cnt_q + 13'd1;
        state_d = (cnt_q == len_q) ? DONE : DATA;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      bp_q <= 1'b1;
      sfifo_wr_q <= 1'b0;
      ptr_wr_q <= 1'b0;
      ptr_din_q <= '0;
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      bp_q <= (sfifo_cnt > BP_TH) || ptr_sfifo_full;
      sfifo_wr_q <= (state_q == DATA) && !err_q;
      ptr_wr_q <= (state_q == DONE) && !err_q;
      if (state_q == DONE && !err_q) ptr_din_q <= {1'b0, sel_q, len_q[LEN_W-1:0]};
      if (state_q == DONE && !err_q && !(&pkt_q)) pkt_q <= pkt_q + 16'd1;
      if (state_q == DONE && err_q && !(&drop_q)) drop_q <= drop_q + 16'd1;
    end
  end
  assign rx_ptr_fifo_rd = (state_q == GRANT) ? sel_q : '0;
  assign rx_data_fifo_rd = (state_q == DATA) ? sel_q : '0;
  // Source byte appears on dout the cycle after its read, aligned with the registered write strobe.
  assign sfifo_wr = sfifo_wr_q;
  assign sfifo_din = sfifo_wr_q ? dat_byte : 8'h0;
  assign ptr_sfifo_wr = ptr_wr_q;
  assign ptr_sfifo_din = ptr_din_q;
  assign pkt_cnt = pkt_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_ingress_mux_nport.sv
// tb_ingress_mux_nport: directed bench for ingress_mux_nport with modelled source FIFOs
module tb_ingress_mux_nport;
  localparam int N = 4;
  logic clk_sys = 1'b0;
  logic rstn_sys = 1'b0;
  logic [N-1:0] port_en, rx_ptr_fifo_empty, rx_ptr_fifo_rd, rx_data_fifo_rd;
  logic [16*N-1:0] rx_ptr_fifo_dout = '0;
  logic [8*N-1:0] rx_data_fifo_dout = '0;
  logic sfifo_wr, ptr_sfifo_wr, ptr_sfifo_full;
  logic [7:0] sfifo_din;
  logic [11:0] sfifo_cnt;
  logic [15:0] ptr_sfifo_din, pkt_cnt, drop_cnt;
  always #5 clk_sys = ~clk_sys;
  ingress_mux_nport dut (
    .clk_sys(clk_sys), .rstn_sys(rstn_sys), .port_en(port_en),
    .rx_ptr_fifo_empty(rx_ptr_fifo_empty), .rx_ptr_fifo_rd(rx_ptr_fifo_rd),
    .rx_ptr_fifo_dout(rx_ptr_fifo_dout), .rx_data_fifo_rd(rx_data_fifo_rd),
    .rx_data_fifo_dout(rx_data_fifo_dout), .sfifo_wr(sfifo_wr), .sfifo_din(sfifo_din),
    .sfifo_cnt(sfifo_cnt), .ptr_sfifo_wr(ptr_sfifo_wr), .ptr_sfifo_din(ptr_sfifo_din),
    .ptr_sfifo_full(ptr_sfifo_full), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  logic [15:0] pmem [N][16];
  logic [7:0] dmem [N][4096];
  int pwr [N] = '{default: 0};
  int dwr [N] = '{default: 0};
  int prd [N] = '{default: 0};
  int drd [N] = '{default: 0};
  always @(posedge clk_sys)
    for (int k = 0; k < N; k++) begin
      if (rx_ptr_fifo_rd[k]) begin
        rx_ptr_fifo_dout[16*k +: 16] <= pmem[k][prd[k] % 16];
        prd[k] <= prd[k] + 1;
      end
      if (rx_data_fifo_rd[k]) begin
        rx_data_fifo_dout[8*k +: 8] <= dmem[k][drd[k] % 4096];
        drd[k] <= drd[k] + 1;
      end
    end
  always_comb
    for (int k = 0; k < N; k++) rx_ptr_fifo_empty[k] = (pwr[k] == prd[k]);
  int n_wr = 0, n_pw = 0, n_drd = 0, n_g = 0, last_wr_cyc = 0, pw_cyc = 0;
  logic [15:0] last_ptr = '0;
  logic [7:0] cap [4096];
  logic [3:0] glog [64];
  int gcyc [64];
  always @(negedge clk_sys)
    if (rstn_sys) begin
      if (sfifo_wr) begin
        cap[n_wr % 4096] = sfifo_din;
        n_wr++;
        last_wr_cyc = cyc;
      end
      if (ptr_sfifo_wr) begin
        last_ptr = ptr_sfifo_din;
        n_pw++;
        pw_cyc = cyc;
      end
      n_drd += $countones(rx_data_fifo_rd);
      if (|rx_ptr_fifo_rd && n_g < 64) begin
        glog[n_g] = rx_ptr_fifo_rd;
        gcyc[n_g] = cyc;
        n_g++;
      end
    end
  int n_cmp = 0, n_mis = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int k, input logic [15:0] p, input int n, input int base);
    for (int i = 0; i < n; i++) dmem[k][(dwr[k] + i) % 4096] = 8'(base + i);
    dwr[k] += n;
    pmem[k][pwr[k] % 16] = p;
    pwr[k]++;
  endtask
  task automatic run_until(input int tot, input int budget, input string tag);
    int i = 0;
    while (32'(pkt_cnt) + 32'(drop_cnt) != tot && i < budget) begin
      @(negedge clk_sys); #1;
      i++;
    end
    check(tag, 32'(pkt_cnt) + 32'(drop_cnt), tot);
    repeat (2) @(negedge clk_sys);
    #1;
  endtask
  task automatic bytes_chk(input string tag, input int start, input int n, input int base);
    int bad = 0;
    for (int i = 0; i < n; i++) if (cap[(start + i) % 4096] !== 8'(base + i)) bad++;
    check(tag, bad, 0);
  endtask
  int a_ord [6] = '{1, 2, 8, 1, 2, 8};
  int a_base [6] = '{'h00, 'h40, 'h80, 'h10, 'h50, 'h90};
  int w0, g0, pw0, d0, c0, hit;
  initial begin
    port_en = '0;
    sfifo_cnt = '0;
    ptr_sfifo_full = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1;
    check("rst_sfifo_wr", sfifo_wr, 0);
    check("rst_ptr_wr", ptr_sfifo_wr, 0);
    check("rst_ptr_din", ptr_sfifo_din, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    rstn_sys = 1'b1;
    port_en = 4'hF;
    repeat (2) @(negedge clk_sys);
    #1;
    w0 = n_wr; g0 = n_g; pw0 = n_pw;
    for (int f = 0; f < 6; f++) push(f % 3 == 2 ? 3 : f % 3, 16'd60, 60, a_base[f]);
    run_until(6, 800, "a_done");
    for (int i = 0; i < 6; i++) check($sformatf("a_gnt%0d", i), 32'(glog[g0 + i]), a_ord[i]);
    for (int i = 0; i < 5; i++) check($sformatf("a_gap%0d", i), gcyc[g0 + i + 1] - gcyc[g0 + i], 64);
    for (int f = 0; f < 6; f++) bytes_chk($sformatf("a_bytes%0d", f), w0 + 60 * f, 60, a_base[f]);
    check("a_wr", n_wr - w0, 360);
    check("a_pw", n_pw - pw0, 6);
    w0 = n_wr; pw0 = n_pw;
    push(2, 16'h0040, 64, 0);
    run_until(7, 200, "b_done");
    check("b_wr", n_wr - w0, 64);
    bytes_chk("b_bytes", w0, 64, 0);
    check("b_pw", n_pw - pw0, 1);
    check("b_ptr", last_ptr, 16'h2040);
    check("b_ptr_lat", pw_cyc - last_wr_cyc, 1);
    check("b_pkt", pkt_cnt, 7);
    w0 = n_wr; pw0 = n_pw; d0 = n_drd;
    push(1, 16'h2040, 64, 'hA0);
    push(1, 16'h0040, 64, 'hC0);
    run_until(9, 400, "c_done");
    check("c_rd", n_drd - d0, 128);
    check("c_wr", n_wr - w0, 64);
    bytes_chk("c_bytes", w0, 64, 'hC0);
    check("c_pw", n_pw - pw0, 1);
    check("c_ptr", last_ptr, 16'h1040);
    check("c_drop", drop_cnt, 1);
    check("c_pkt", pkt_cnt, 8);
    w0 = n_wr; pw0 = n_pw; d0 = n_drd;
    push(0, 16'h0000, 0, 0);
    push(0, 16'h0640, 1600, 'h11);
    run_until(11, 2000, "d_done");
    check("d_rd", n_drd - d0, 1600);
    check("d_wr", n_wr - w0, 0);
    check("d_pw", n_pw - pw0, 0);
    check("d_drop", drop_cnt, 3);
    sfifo_cnt = 12'd2600;
    repeat (2) @(negedge clk_sys);
    #1;
    g0 = n_g; w0 = n_wr;
    push(3, 16'd8, 8, 'h30);
    repeat (20) @(negedge clk_sys);
    #1;
    check("e_hold", n_g - g0, 0);
    check("e_pending", rx_ptr_fifo_empty[3], 0);
    @(negedge clk_sys);
    #1;
    sfifo_cnt = 12'd2578;
    c0 = cyc;
    for (int i = 0; i < 10 && n_g == g0; i++) begin
      @(negedge clk_sys); #1;
    end
    check("e_gnt_lat", gcyc[g0] - c0, 2);
    repeat (3) @(negedge clk_sys);
    #1;
    ptr_sfifo_full = 1'b1;
    run_until(12, 100, "e_done");
    check("e_wr", n_wr - w0, 8);
    bytes_chk("e_bytes", w0, 8, 'h30);
    ptr_sfifo_full = 1'b0;
    sfifo_cnt = '0;
    repeat (2) @(negedge clk_sys);
    #1;
    port_en = 4'b1011;
    g0 = n_g;
    push(0, 16'd4, 4, 1);
    push(1, 16'd4, 4, 2);
    push(2, 16'd16, 16, 'h60);
    push(3, 16'd4, 4, 3);
    run_until(15, 100, "f_done");
    repeat (10) @(negedge clk_sys);
    #1;
    check("f_ngnt", n_g - g0, 3);
    hit = 0;
    for (int i = g0; i < n_g; i++) if (glog[i][2]) hit++;
    check("f_p2_gnt", hit, 0);
    check("f_p2_pending", rx_ptr_fifo_empty[2], 0);
    port_en = 4'hF;
    for (int i = 0; i < 20 && rx_data_fifo_rd == '0; i++) begin
      @(negedge clk_sys); #1;
    end
    check("g_data_rd", rx_data_fifo_rd, 4'b0100);
    repeat (3) @(negedge clk_sys);
    #1;
    check("g_pre_wr", sfifo_wr, 1);
    check("g_pre_pkt", pkt_cnt, 12);
    rstn_sys = 1'b0;
    #1;
    check("g_rd_data", rx_data_fifo_rd, 0);
    check("g_rd_ptr", rx_ptr_fifo_rd, 0);
    check("g_wr", sfifo_wr, 0);
    check("g_din", sfifo_din, 0);
    check("g_pw", ptr_sfifo_wr, 0);
    check("g_pdin", ptr_sfifo_din, 0);
    check("g_pkt", pkt_cnt, 0);
    check("g_drop", drop_cnt, 0);
    repeat (2) @(negedge clk_sys);
    rstn_sys = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/ingress_mux_nport.md
# ingress_mux_nport

Parametrised N-port ingress multiplexer for the switch core. It arbitrates round-robin among the per-MAC receive FIFO pairs (data FIFO and pointer FIFO) and copies one whole frame at a time into the shared backend data FIFO and pointer FIFO, which sit outside this block. Frames that are flagged errored, zero-length or oversize are drained from the source and counted, never forwarded. The frame pointer is written only after the frame's last byte, so the backend never sees a pointer ahead of its data.

## Interface
- NPORTS, 4: number of ingress MAC ports, 2..8.
- LEN_W, 11: width of the length field in the output pointer.
- MAX_LEN, 1518: largest accepted frame in bytes. Must be < 2^LEN_W.
- DCNT_W, 12: width of the backend data-FIFO occupancy count.
- DATA_DEPTH, 4096: backend data-FIFO depth in bytes.
- clk_sys  in  1  system clock.
- rstn_sys  in  1  reset. One clock; reset is asynchronous and active-low.
- port_en  in  NPORTS  per-port enable. A cleared bit masks that port's request.
- rx_ptr_fifo_empty  in  NPORTS  per-port pointer FIFO empty.
- rx_ptr_fifo_rd  out  NPORTS  per-port pointer FIFO read strobe, one-hot.
- rx_ptr_fifo_dout  in  16*NPORTS  port k occupies bits [16k+15:16k]; format {err[2:0], len[12:0]}.
- rx_data_fifo_rd  out  NPORTS  per-port data FIFO read strobe, one-hot.
- rx_data_fifo_dout  in  8*NPORTS  port k occupies bits [8k+7:8k].
- sfifo_wr  out  1  backend data FIFO write.
- sfifo_din  out  8  backend data byte.
- sfifo_cnt  in  DCNT_W  backend data FIFO occupancy.
- ptr_sfifo_wr  out  1  backend pointer FIFO write.
- ptr_sfifo_din  out  1+NPORTS+LEN_W  output pointer, {1'b0, source one-hot, len[LEN_W-1:0]}.
- ptr_sfifo_full  in  1  backend pointer FIFO full.
- pkt_cnt  out  16  forwarded-frame count; saturates at 0xFFFF.
- drop_cnt  out  16  dropped-frame count; saturates at 0xFFFF.

## Operation
- Source FIFOs are standard (not first-word-fall-through): dout is valid the cycle after rd.
- A port requests when port_en[k] is set and rx_ptr_fifo_empty[k] is clear.
- The state machine is one-hot with five states: IDLE, GRANT, HDR, DATA, DONE.
- IDLE → GRANT when any port requests and bp is 0. The grant is registered into sel (one-hot) and the round-robin pointer.
- GRANT: rx_ptr_fifo_rd = sel for exactly one cycle. Then → HDR.
- HDR: capture len_r = dout[12:0] of the selected port. Set err_r = |dout[15:13] OR len_r == 0 OR len_r > MAX_LEN.
  - If len_r == 0 → DONE.
  - Otherwise → DATA, with cnt = 1.
- DATA: rx_data_fifo_rd = sel every cycle; cnt increments each cycle. → DONE on the cycle with cnt == len_r, so exactly len_r reads occur.
  - Errored frames are still read in full (drain), but nothing is written.
- DONE: one cycle, then → IDLE.
- Round-robin: the winner is the lowest-index requester at or above the pointer, wrapping around. After a grant to port k, pointer = (k+1) mod NPORTS. Pointer reset value is 0.
- Backpressure: bp is registered each cycle as (sfifo_cnt > DATA_DEPTH − MAX_LEN) OR ptr_sfifo_full. Reset value is 1. bp is sampled only in IDLE; a frame in progress always completes.
- Counters: in DONE, pkt_cnt increments if !err_r, otherwise drop_cnt increments. Both saturate.
- Output pointer length field is len_r[LEN_W-1:0]. This is valid because len ≤ MAX_LEN < 2^LEN_W.

## Timing
- Reset values:
  - All outputs are 0.
  - Internal state: state = IDLE, pointer = 0, bp = 1.
  - Reset asserted mid-frame aborts immediately. The partial frame remains in the source FIFO; this is a system-level reset.
- sfifo_wr and sfifo_din are registered: they follow the corresponding rx_data_fifo_rd by exactly 1 cycle. sfifo_wr = (data read last cycle) AND !err_r.
- ptr_sfifo_wr is registered from DONE and pulses 1 cycle, the cycle after DONE. It therefore comes 1 cycle after the last sfifo_wr. It is suppressed when err_r is set.
- rx_ptr_fifo_rd and rx_data_fifo_rd are decoded combinationally from state and sel.
- Frame occupancy is len+4 cycles (IDLE, GRANT, HDR, len×DATA, DONE). Back-to-back frames start every len+4 cycles.
- A request that appears in DONE is arbitrated in the following IDLE cycle.

## Test plan
- Port 2 only, ptr 0x0040 (len 64), bytes 0x00..0x3F → 64 sfifo_wr pulses with matching bytes. ptr_sfifo_din = {0, 4'b0100, 11'd64}, one cycle after the last byte. pkt_cnt = 1.
- Ports 0, 1, 3 each hold 2 frames of len 60 → grant order 0, 1, 3, 0, 1, 3. Frame starts are 64 cycles apart.
- Port 1 ptr 0x2040 (err bit 13, len 64) → 64 rx_data_fifo_rd pulses, zero sfifo_wr, no ptr write, drop_cnt = 1. The next frame on port 1 forwards intact.
- len 0 and len 1600 frames → len 0: no data reads. len 1600: 1600 reads. Both produce no writes, and drop_cnt increments by 2.
- sfifo_cnt = 2600 with a request pending → held in IDLE. At sfifo_cnt = 2578, GRANT occurs 2 cycles later. Assert ptr_sfifo_full mid-frame → the frame completes.
- port_en = 4'b1011 with all ports requesting → port 2 is never granted. Pulse rstn_sys low mid-DATA → all outputs are 0 the same cycle and pkt_cnt = 0.
